// File: rtl/sisc_fetch_unit.sv
// SISC instruction-fetch stage: owns PC and IR, reads instruction memory
// over a req/ack handshake, applies branch redirects and latches HLT.
module sisc_fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               fetch_req,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               ir_valid,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [3:0]         rd,
  output logic [3:0]         rs,
  output logic [3:0]         rt,
  output logic [15:0]        imm,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    LOADED = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam logic [3:0] OP_HLT = 4'hF;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc_n;
  logic [INSTR_W-1:0]  ir, ir_n;
  logic                ir_valid_n;
  logic                imem_req_n;
  logic [ADDR_W-1:0]   imem_addr_n;
  logic                halted_n;
  logic                br_pend, br_pend_n;
  logic [ADDR_W-1:0]   br_tgt, br_tgt_n;

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    ir_n        = ir;
    ir_valid_n  = ir_valid;
    imem_req_n  = imem_req;
    imem_addr_n = imem_addr;
    halted_n    = halted;
    br_pend_n   = br_pend;
    br_tgt_n    = br_tgt;

    unique case (state)
      IDLE, LOADED: begin
        if (br_taken) begin
          pc_n = br_addr;
        end
        if (fetch_req) begin
          state_n     = REQ;
          imem_req_n  = 1'b1;
          // A simultaneous redirect wins over the stale PC for the address.
          imem_addr_n = br_taken ? br_addr : pc;
          ir_valid_n  = 1'b0;
        end
      end
      REQ: begin
        // Redirects arriving while the read is outstanding are remembered;
        // the most recent one is the one applied at ack.
        if (br_taken) begin
          br_pend_n = 1'b1;
          br_tgt_n  = br_addr;
        end
        if (imem_ack) begin
          ir_n       = imem_data;
          ir_valid_n = 1'b1;
          imem_req_n = 1'b0;
          br_pend_n  = 1'b0;
          if (br_taken)     pc_n = br_addr;
          else if (br_pend) pc_n = br_tgt;
          else              pc_n = pc + ADDR_W'(1);
          if (imem_data[31:28] == OP_HLT) begin
            state_n  = HALT;
            halted_n = 1'b1;
          end else begin
            state_n  = LOADED;
          end
        end
      end
      HALT: begin
        // Terminal until reset.
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst_f) begin
      state     <= IDLE;
      pc        <= '0;
      ir        <= '0;
      ir_valid  <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      halted    <= 1'b0;
      br_pend   <= 1'b0;
      br_tgt    <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      ir        <= ir_n;
      ir_valid  <= ir_valid_n;
      imem_req  <= imem_req_n;
      imem_addr <= imem_addr_n;
      halted    <= halted_n;
      br_pend   <= br_pend_n;
      br_tgt    <= br_tgt_n;
    end
  end

  assign opcode = ir[31:28];
  assign mm     = ir[27:24];
  assign rd     = ir[23:20];
  assign rs     = ir[19:16];
  assign rt     = ir[15:12];
  assign imm    = ir[15:0];

endmodule
